high_freq_fir: RTL and testbench

HIGH_FREQ_FIR -- requirements
Module: high_freq_fir

---
 rtl/high_freq_fir.sv | 140 ++++++++++++++
 tb/tb_high_freq_fir.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/high_freq_fir.sv
// Stereo FIR: one MAC per tap over a sequenced frame, 42-bit accumulate, saturating 16-bit output.
// Result and valid appear N_TAPS+3 cycles after the start edge; no backpressure, upstream paces the frame.
module high_freq_fir #(
    parameter int N_TAPS   = 1021,
    parameter int COEFF_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sequencing,
    input  logic [15:0]         lft_in,
    input  logic [15:0]         rght_in,
    output logic [COEFF_AW-1:0] coeff_addr,
    input  logic [15:0]         coeff,
    output logic [15:0]         lft_out,
    output logic [15:0]         rght_out,
    output logic                valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [COEFF_AW-1:0] cnt_q, cnt_d;
    logic                seq_prev_q;
    logic                v1_q, v2_q;
    logic signed [31:0]  lprod_q, rprod_q, lprod_d, rprod_d;
    logic signed [41:0]  lacc_q, racc_q, lacc_d, racc_d;
    logic [15:0]         lft_out_q, rght_out_q, lft_out_d, rght_out_d;
    logic                valid_q;

    logic start, abort, last_tap, drain_done, tap_fire;

    function automatic logic [15:0] sat16(input logic [41:0] a);
        if ((&a[41:30]) || !(|a[41:30]))
            return a[30:15];
        else
            return a[41] ? 16'h8000 : 16'h7FFF;
    endfunction

    assign start      = (state_q == S_IDLE) && sequencing && !seq_prev_q;
    assign abort      = (state_q == S_MAC) && !sequencing;
    assign last_tap   = (cnt_q == COEFF_AW'(N_TAPS - 1));
    assign drain_done = (state_q == S_DRAIN) && (cnt_q == COEFF_AW'(2));
    assign tap_fire   = start || ((state_q == S_MAC) && !abort);

    // Tap 0 is addressed from IDLE in the start cycle, so MAC begins at tap 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (N_TAPS == 1) ? S_DRAIN : S_MAC;
                    cnt_d   = (N_TAPS == 1) ? '0 : COEFF_AW'(1);
                end
            end
            S_MAC: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last_tap) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + COEFF_AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + COEFF_AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lprod_d    = $signed(lft_in) * $signed(coeff);
        rprod_d    = $signed(rght_in) * $signed(coeff);
        lacc_d     = lacc_q;
        racc_d     = racc_q;
        lft_out_d  = lft_out_q;
        rght_out_d = rght_out_q;
        // Start clear outranks any product still in flight from an aborted frame.
        if (start) begin
            lacc_d = '0;
            racc_d = '0;
        end else if (v2_q) begin
            lacc_d = lacc_q + {{10{lprod_q[31]}}, lprod_q};
            racc_d = racc_q + {{10{rprod_q[31]}}, rprod_q};
        end
        if (drain_done) begin
            lft_out_d  = sat16(lacc_q);
            rght_out_d = sat16(racc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            seq_prev_q <= 1'b1;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            lprod_q    <= '0;
            rprod_q    <= '0;
            lacc_q     <= '0;
            racc_q     <= '0;
            lft_out_q  <= '0;
            rght_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_prev_q <= sequencing;
            v1_q       <= tap_fire;
            v2_q       <= v1_q;
            lprod_q    <= lprod_d;
            rprod_q    <= rprod_d;
            lacc_q     <= lacc_d;
            racc_q     <= racc_d;
            lft_out_q  <= lft_out_d;
            rght_out_q <= rght_out_d;
            valid_q    <= drain_done;
        end
    end

    assign coeff_addr = (state_q == S_MAC) ? cnt_q : '0;
    assign lft_out    = lft_out_q;
    assign rght_out   = rght_out_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_high_freq_fir.sv
// Directed bench for high_freq_fir: sample queue and coefficient ROM modelled with one-cycle latency.
module tb_high_freq_fir;

    localparam int N = 1021;

    logic        clk = 1'b0;
    logic        rst;
    logic        sequencing;
    logic [15:0] lft_in, rght_in, coeff;
    logic [9:0]  coeff_addr;
    logic [15:0] lft_out, rght_out;
    logic        valid;

    logic [15:0] lsmp [0:N-1];
    logic [15:0] rsmp [0:N-1];
    logic [15:0] crom [0:N-1];

    int tests = 0;
    int fails = 0;

    high_freq_fir #(.N_TAPS(N), .COEFF_AW(10)) dut (
        .clk(clk), .rst(rst), .sequencing(sequencing),
        .lft_in(lft_in), .rght_in(rght_in),
        .coeff_addr(coeff_addr), .coeff(coeff),
        .lft_out(lft_out), .rght_out(rght_out), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            lsmp[i] = 16'h0;
            rsmp[i] = 16'h0;
            crom[i] = 16'h0;
        end
    endtask

    // Runs 'total' cycles from the current negedge; cycle 0 is the start cycle.
    task automatic drive_frame(input int seq_len, input int total,
                               output int vcyc, output int vcnt, output int aerr,
                               output logic [15:0] lo, output logic [15:0] ro);
        int aprev;
        int exp_a;
        aprev = 0;
        vcyc  = -1;
        vcnt  = 0;
        aerr  = 0;
        lo    = 16'hxxxx;
        ro    = 16'hxxxx;
        for (int c = 0; c < total; c++) begin
            exp_a = (c < N && c <= seq_len) ? c : 0;
            if (coeff_addr !== 10'(exp_a)) aerr++;
            if (valid === 1'b1) begin
                vcnt++;
                vcyc = c;
                lo   = lft_out;
                ro   = rght_out;
            end
            sequencing = (c < seq_len);
            lft_in     = (c >= 1 && c <= N) ? lsmp[c-1] : 16'h0;
            rght_in    = (c >= 1 && c <= N) ? rsmp[c-1] : 16'h0;
            coeff      = crom[aprev];
            aprev      = int'(coeff_addr);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk);
        tests++; if (lft_out !== 16'h0) begin fails++; $display("FAIL reset_lft_out: got %h expected 0000", lft_out); end
        tests++; if (rght_out !== 16'h0) begin fails++; $display("FAIL reset_rght_out: got %h expected 0000", rght_out); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (coeff_addr !== 10'h0) begin fails++; $display("FAIL reset_coeff_addr: got %h expected 000", coeff_addr); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (coeff_addr !== 10'h0 || valid !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL reset_no_start_high_seq: got %0d active cycles expected 0", bad); end
        sequencing = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_impulse();
        int vcyc, vcnt, aerr;
        logic [15:0] lo, ro;
        clear_mem();
        lsmp[0] = 16'h4000;
        crom[0] = 16'h4000;
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (aerr != 0) begin fails++; $display("FAIL impulse_addr_seq: got %0d bad cycles expected 0", aerr); end
        tests++; if (vcnt != 1) begin fails++; $display("FAIL impulse_valid_count: got %0d expected 1", vcnt); end
        tests++; if (vcyc != N + 3) begin fails++; $display("FAIL impulse_valid_cycle: got %0d expected %0d", vcyc, N + 3); end
        tests++; if (lo !== 16'h2000) begin fails++; $display("FAIL impulse_lft: got %h expected 2000", lo); end
        tests++; if (ro !== 16'h0000) begin fails++; $display("FAIL impulse_rght: got %h expected 0000", ro); end
        sequencing = 1'b0;
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL impulse_valid_width: got %b expected 0", valid); end
        @(negedge clk);
        tests++; if (lft_out !== 16'h2000) begin fails++; $display("FAIL impulse_hold: got %h expected 2000", lft_out); end
    endtask

    task automatic test_saturation();
        int vcyc, vcnt, aerr;
        logic [15:0] lo, ro;
        for (int i = 0; i < N; i++) begin
            lsmp[i] = 16'h7FFF;
            rsmp[i] = 16'h8000;
            crom[i] = 16'h7FFF;
        end
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (vcyc != N + 3 || vcnt != 1) begin fails++; $display("FAIL sat_valid: got cycle %0d count %0d expected cycle %0d count 1", vcyc, vcnt, N + 3); end
        tests++; if (lo !== 16'h7FFF) begin fails++; $display("FAIL sat_lft: got %h expected 7fff", lo); end
        tests++; if (ro !== 16'h8000) begin fails++; $display("FAIL sat_rght: got %h expected 8000", ro); end
    endtask

    task automatic test_abort();
        int vcyc, vcnt, aerr;
        logic [15:0] lo, ro;
        clear_mem();
        lsmp[0] = 16'h4000;
        crom[0] = 16'h4000;
        drive_frame(500, 1100, vcyc, vcnt, aerr, lo, ro);
        tests++; if (vcnt != 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses expected 0", vcnt); end
        tests++; if (aerr != 0) begin fails++; $display("FAIL abort_addr_idle: got %0d bad cycles expected 0", aerr); end
        tests++; if (lft_out !== 16'h7FFF) begin fails++; $display("FAIL abort_lft_hold: got %h expected 7fff", lft_out); end
        tests++; if (rght_out !== 16'h8000) begin fails++; $display("FAIL abort_rght_hold: got %h expected 8000", rght_out); end
        // Two leading taps plus the last tap: 0x1000_0000 + 0x0800_0000 + 0x1_0000 -> 0x3002.
        clear_mem();
        lsmp[0]   = 16'h4000; crom[0]   = 16'h4000;
        lsmp[1]   = 16'h2000; crom[1]   = 16'h4000;
        lsmp[N-1] = 16'h0100; crom[N-1] = 16'h0100;
        rsmp[0]   = 16'hC000;
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (vcyc != N + 3) begin fails++; $display("FAIL post_abort_valid: got %0d expected %0d", vcyc, N + 3); end
        tests++; if (lo !== 16'h3002) begin fails++; $display("FAIL post_abort_lft: got %h expected 3002", lo); end
        tests++; if (ro !== 16'hE000) begin fails++; $display("FAIL post_abort_rght: got %h expected e000", ro); end
    endtask

    task automatic test_back_to_back();
        int vcyc, vcnt, aerr;
        logic [15:0] lo, ro;
        clear_mem();
        lsmp[0] = 16'h4000;
        crom[0] = 16'h4000;
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (lo !== 16'h2000 || vcyc != N + 3) begin fails++; $display("FAIL b2b_first: got %h at %0d expected 2000 at %0d", lo, vcyc, N + 3); end
        crom[0] = 16'h0000;
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (vcyc != N + 3 || vcnt != 1) begin fails++; $display("FAIL b2b_second_valid: got cycle %0d count %0d expected %0d count 1", vcyc, vcnt, N + 3); end
        tests++; if (lo !== 16'h0000) begin fails++; $display("FAIL b2b_second_lft: got %h expected 0000", lo); end
    endtask

    task automatic test_reset_mid();
        int vcyc, vcnt, aerr, bad;
        logic [15:0] lo, ro;
        clear_mem();
        lsmp[0] = 16'h4000;
        crom[0] = 16'h4000;
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (lo !== 16'h2000) begin fails++; $display("FAIL rstmid_pre: got %h expected 2000", lo); end
        drive_frame(N, 300, vcyc, vcnt, aerr, lo, ro);
        rst = 1'b1;
        #1;
        tests++; if (lft_out !== 16'h0 || rght_out !== 16'h0) begin fails++; $display("FAIL rstmid_outputs: got %h/%h expected 0000/0000", lft_out, rght_out); end
        tests++; if (coeff_addr !== 10'h0 || valid !== 1'b0) begin fails++; $display("FAIL rstmid_addr_valid: got %h/%b expected 000/0", coeff_addr, valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (coeff_addr !== 10'h0 || valid !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_no_restart: got %0d active cycles expected 0", bad); end
        sequencing = 1'b0;
        repeat (2) @(negedge clk);
        drive_frame(N, N + 4, vcyc, vcnt, aerr, lo, ro);
        tests++; if (lo !== 16'h2000 || vcyc != N + 3) begin fails++; $display("FAIL rstmid_next_frame: got %h at %0d expected 2000 at %0d", lo, vcyc, N + 3); end
    endtask

    initial begin
        rst        = 1'b1;
        sequencing = 1'b1;
        lft_in     = 16'h0;
        rght_in    = 16'h0;
        coeff      = 16'h0;
        clear_mem();
        test_reset();
        test_impulse();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
